// File: rtl/bus_master_arb_pkg.sv
// Shared bus-arbitration types and constants for the system bus master side.
package bus_master_arb_pkg;

  // Active-low bus signalling levels.
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // Fixed master slots used by the CPU core.
  localparam logic [2:0] BUS_MST_IF  = 3'd0;
  localparam logic [2:0] BUS_MST_MEM = 3'd1;

  // Bus owner index (up to eight masters).
  typedef logic [2:0] bus_owner_t;

  // Arbiter state encoding.
  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // True when an active-low strobe/request/ready line is asserted.
  function automatic logic is_asserted(input logic sig_);
    return (sig_ == ENABLE_);
  endfunction

endpackage

// File: rtl/bus_master_arb_rr_pick.sv
// Round-robin requester picker: scans last+1, last+2, ... (mod N_MST) and
// returns the first requesting master that is not masked out.
module bus_rr_pick
  import bus_master_arb_pkg::*;
#(
  parameter int N_MST = 4
) (
  input  logic [N_MST-1:0] req,
  input  bus_owner_t       last,
  input  logic [N_MST-1:0] excl,
  output bus_owner_t       pick,
  output logic             found
);

  logic [7:0] cand_s;
  logic [3:0] idx_s;

  // Circular first-match search starting just after the last owner.
  always_comb begin
    cand_s = 8'(req & ~excl);
    pick   = 3'd0;
    found  = 1'b0;
    idx_s  = 4'd0;
    for (int k = 1; k <= N_MST; k++) begin
      idx_s = {1'b0, last} + 4'(k);
      if (idx_s >= 4'(N_MST)) begin
        idx_s = idx_s - 4'(N_MST);
      end else begin
        idx_s = idx_s;
      end
      if (!found && cand_s[idx_s[2:0]]) begin
        found = 1'b1;
        pick  = idx_s[2:0];
      end else begin
        found = found;
        pick  = pick;
      end
    end
  end

endmodule

// File: rtl/bus_master_arb.sv
// Round-robin bus arbiter and master-side multiplexer with a stalled-transfer
// watchdog that revokes the owner's grant when the slave never answers.
module bus_master_arb
  import bus_master_arb_pkg::*;
#(
  parameter int N_MST   = 4,
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_MST-1:0]        m_req_,
  output logic [N_MST-1:0]        m_grnt_,
  input  logic [N_MST-1:0]        m_as_,
  input  logic [N_MST*ADDR_W-1:0] m_addr,
  input  logic [N_MST-1:0]        m_rw,
  input  logic [N_MST*DATA_W-1:0] m_wr_data,
  input  logic                    s_rdy_,
  output logic                    s_as_,
  output logic [ADDR_W-1:0]       s_addr,
  output logic                    s_rw,
  output logic [DATA_W-1:0]       s_wr_data,
  output logic [2:0]              owner,
  output logic                    busy,
  output logic                    timeout,
  output logic [2:0]              timeout_mst
);

  // A zero TIMEOUT still needs a legal one-bit counter that is held at zero.
  localparam int WDOG_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT);
  localparam logic [WDOG_W-1:0] WDOG_MAX   = {WDOG_W{1'b1}};

  arb_state_e         state_r;
  arb_state_e         state_nxt_s;
  bus_owner_t         owner_r;
  bus_owner_t         last_r;
  logic [N_MST-1:0]   grnt_r;
  logic               busy_r;
  logic               timeout_r;
  bus_owner_t         timeout_mst_r;
  logic [WDOG_W-1:0]  wdog_r;
  logic               pending_r;

  logic [7:0]         req8_s;
  logic [7:0]         as8_s;
  logic [7:0]         rw8_s;
  logic [ADDR_W-1:0]  addr_arr_s [8];
  logic [DATA_W-1:0]  data_arr_s [8];
  logic [N_MST-1:0]   excl_s;
  logic [N_MST-1:0]   pick_grnt_s;
  bus_owner_t         pick_s;
  logic               found_s;
  logic               owner_req_s;
  logic               expire_s;
  logic               load_s;
  logic               release_s;
  logic               tmo_s;
  logic               grant_chg_s;

  assign m_grnt_     = grnt_r;
  assign owner       = owner_r;
  assign busy        = busy_r;
  assign timeout     = timeout_r;
  assign timeout_mst = timeout_mst_r;

  // Spread the packed master buses into eight padded slots so the owner index selects directly.
  always_comb begin
    req8_s = 8'h00;
    as8_s  = 8'hFF;
    rw8_s  = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      addr_arr_s[i] = {ADDR_W{1'b0}};
      data_arr_s[i] = {DATA_W{1'b0}};
    end
    for (int i = 0; i < N_MST; i++) begin
      req8_s[i]     = is_asserted(m_req_[i]);
      as8_s[i]      = m_as_[i];
      rw8_s[i]      = m_rw[i];
      addr_arr_s[i] = m_addr[i*ADDR_W +: ADDR_W];
      data_arr_s[i] = m_wr_data[i*DATA_W +: DATA_W];
    end
  end

  // While granted, the current owner is excluded so a release or revoke hands off to someone else.
  always_comb begin
    excl_s      = {N_MST{1'b0}};
    pick_grnt_s = {N_MST{1'b1}};
    for (int i = 0; i < N_MST; i++) begin
      excl_s[i]      = (state_r == ARB_GRANT) && (owner_r == 3'(i));
      pick_grnt_s[i] = (pick_s == 3'(i)) ? ENABLE_ : DISABLE_;
    end
  end

  bus_rr_pick #(
    .N_MST (N_MST)
  ) u_pick (
    .req   (req8_s[N_MST-1:0]),
    .last  (last_r),
    .excl  (excl_s),
    .pick  (pick_s),
    .found (found_s)
  );

  // Owner still requesting, and watchdog expiry (a ready on the expiry cycle suppresses it).
  always_comb begin
    owner_req_s = req8_s[owner_r];
    if ((TIMEOUT > 0) && (state_r == ARB_GRANT) && (wdog_r == WDOG_LIMIT) &&
        !is_asserted(s_rdy_)) begin
      expire_s = 1'b1;
    end else begin
      expire_s = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ARB_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: grant, hand off on release or revoke, or fall back to idle.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    release_s   = 1'b0;
    tmo_s       = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        if (found_s) begin
          state_nxt_s = ARB_GRANT;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = ARB_IDLE;
        end
      end
      ARB_GRANT: begin
        if (!owner_req_s || expire_s) begin
          // A master dropping its request takes precedence over a same-cycle expiry.
          release_s = !owner_req_s;
          tmo_s     = owner_req_s;
          if (found_s) begin
            state_nxt_s = ARB_GRANT;
            load_s      = 1'b1;
          end else begin
            state_nxt_s = ARB_IDLE;
          end
        end else begin
          state_nxt_s = ARB_GRANT;
        end
      end
      default: begin
        state_nxt_s = ARB_IDLE;
      end
    endcase
  end

  // FSM output: route the owner's bus signals to the slave side, idle values otherwise.
  always_comb begin
    s_as_     = DISABLE_;
    s_addr    = {ADDR_W{1'b0}};
    s_rw      = 1'b1;
    s_wr_data = {DATA_W{1'b0}};
    if (state_r == ARB_GRANT) begin
      s_as_     = as8_s[owner_r];
      s_addr    = addr_arr_s[owner_r];
      s_rw      = rw8_s[owner_r];
      s_wr_data = data_arr_s[owner_r];
    end else begin
      s_as_     = DISABLE_;
    end
  end

  // Grant, owner, round-robin pointer and timeout report registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grnt_r        <= {N_MST{1'b1}};
      busy_r        <= 1'b0;
      owner_r       <= 3'd0;
      last_r        <= 3'(N_MST - 1);
      timeout_r     <= 1'b0;
      timeout_mst_r <= 3'd0;
    end else begin
      timeout_r <= tmo_s;
      if (tmo_s) begin
        timeout_mst_r <= owner_r;
      end
      if (load_s) begin
        owner_r <= pick_s;
        last_r  <= pick_s;
        grnt_r  <= pick_grnt_s;
        busy_r  <= 1'b1;
      end else if (state_nxt_s == ARB_IDLE) begin
        grnt_r  <= {N_MST{1'b1}};
        busy_r  <= 1'b0;
      end
    end
  end

  assign grant_chg_s = load_s | release_s | tmo_s | (state_r == ARB_IDLE);

  // Watchdog: count cycles from the strobe until ready, restarting on every grant change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_r    <= {WDOG_W{1'b0}};
      pending_r <= 1'b0;
    end else begin
      if (grant_chg_s || is_asserted(s_rdy_)) begin
        pending_r <= 1'b0;
      end else if (is_asserted(s_as_)) begin
        pending_r <= 1'b1;
      end
      if ((TIMEOUT == 0) || grant_chg_s || is_asserted(s_rdy_)) begin
        wdog_r <= {WDOG_W{1'b0}};
      end else if ((pending_r || is_asserted(s_as_)) && (wdog_r != WDOG_MAX)) begin
        wdog_r <= wdog_r + {{(WDOG_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_bus_master_arb.sv
// Self-checking bench for bus_master_arb: grant order is tracked by a scoreboard
// queue, everything else is checked directly against bench constants.
module tb_bus_master_arb;

  localparam int N_MST   = 4;
  localparam int ADDR_W  = 30;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic [N_MST-1:0]        m_req_ = 4'hF;
  logic [N_MST-1:0]        m_grnt_;
  logic [N_MST-1:0]        m_as_ = 4'hF;
  logic [N_MST*ADDR_W-1:0] m_addr;
  logic [N_MST-1:0]        m_rw = 4'hF;
  logic [N_MST*DATA_W-1:0] m_wr_data;
  logic                    s_rdy_ = 1'b1;
  logic                    s_as_;
  logic [ADDR_W-1:0]       s_addr;
  logic                    s_rw;
  logic [DATA_W-1:0]       s_wr_data;
  logic [2:0]              owner;
  logic                    busy;
  logic                    timeout;
  logic [2:0]              timeout_mst;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  int tmo_cnt = 0;
  int mon_idx;
  logic [N_MST-1:0] prev_grnt = 4'hF;
  int order[5] = '{0, 1, 2, 3, 0};

  bus_master_arb #(
    .N_MST(N_MST), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .m_req_(m_req_), .m_grnt_(m_grnt_), .m_as_(m_as_),
    .m_addr(m_addr), .m_rw(m_rw), .m_wr_data(m_wr_data), .s_rdy_(s_rdy_),
    .s_as_(s_as_), .s_addr(s_addr), .s_rw(s_rw), .s_wr_data(s_wr_data),
    .owner(owner), .busy(busy), .timeout(timeout), .timeout_mst(timeout_mst)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: grant shape every cycle, timeout pulses, and grant changes against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      if (busy) check_val("grnt_onehot", $countones(~m_grnt_), 1);
      else      check_val("grnt_idle", m_grnt_, 4'hF);
      if (timeout) tmo_cnt++;
      if ((m_grnt_ != prev_grnt) && (m_grnt_ != 4'hF)) begin
        mon_idx = 255;
        for (int i = 0; i < N_MST; i++) if (!m_grnt_[i]) mon_idx = i;
        if (exp_q.size() == 0) check_val("sb_extra", mon_idx, 255);
        else                   check_val("sb_owner", mon_idx, exp_q.pop_front());
      end
    end
    prev_grnt = m_grnt_;
  end

  initial begin
    for (int i = 0; i < N_MST; i++) begin
      m_addr[i*ADDR_W +: ADDR_W]    = ADDR_W'(32'h1000 + i);
      m_wr_data[i*DATA_W +: DATA_W] = 32'hD000_0000 + i;
    end

    // Reset values
    tick(2);
    check_val("rst_grnt", m_grnt_, 4'hF);
    check_val("rst_busy", busy, 0);
    check_val("rst_owner", owner, 0);
    check_val("rst_tmo", timeout, 0);
    check_val("rst_tmo_mst", timeout_mst, 0);
    check_val("rst_s_as", s_as_, 1);
    check_val("rst_s_addr", s_addr, 0);
    check_val("rst_s_rw", s_rw, 1);
    check_val("rst_s_wdata", s_wr_data, 0);
    reset = 1'b1;

    // 1: single request, one-clock latency, mux follows master 0
    tick(1);
    m_req_ = 4'b1110; exp_q.push_back(0);
    #1 check_val("t1_no_early", m_grnt_, 4'hF);
    tick(1);
    check_val("t1_grnt", m_grnt_, 4'b1110);
    check_val("t1_busy", busy, 1);
    check_val("t1_owner", owner, 0);
    check_val("t1_s_addr", s_addr, 30'h1000);
    m_addr[0 +: ADDR_W] = 30'h2AAA_AAAA;
    #1 check_val("t1_s_addr_follow", s_addr, 30'h2AAA_AAAA);
    m_req_ = 4'hF;
    tick(1);
    check_val("t1_idle", busy, 0);

    // 2: all request, each holds 3 clocks, order 0,1,2,3,0 with no idle gap
    reset = 1'b0; tick(1); reset = 1'b1; tick(1);
    m_req_ = 4'b0000;
    for (int g = 0; g < 5; g++) exp_q.push_back(order[g]);
    tick(1);
    for (int g = 0; g < 5; g++) begin
      tick(2);
      m_req_[order[g]] = 1'b1;
      tick(1);
      if (g == 0) m_req_[0] = 1'b0;
      check_val($sformatf("t2_busy%0d", g), busy, (g < 4) ? 1 : 0);
    end

    // 3: owner 1 strobes 30'h100, ready after 5 clocks, no timeout, grant held
    m_addr[1*ADDR_W +: ADDR_W] = 30'h100;
    m_rw[1] = 1'b0;
    m_wr_data[1*DATA_W +: DATA_W] = 32'hCAFE_0001;
    m_req_ = 4'b1101; exp_q.push_back(1);
    tick(1);
    check_val("t3_owner", owner, 1);
    m_as_[2] = 1'b0;
    #1 check_val("t3_nonowner_as", s_as_, 1);
    m_as_[2] = 1'b1; m_as_[1] = 1'b0;
    #1 check_val("t3_s_as", s_as_, 0);
    check_val("t3_s_addr", s_addr, 30'h100);
    check_val("t3_s_rw", s_rw, 0);
    check_val("t3_s_wdata", s_wr_data, 32'hCAFE_0001);
    tick(1);
    m_as_[1] = 1'b1;
    tick(4);
    s_rdy_ = 1'b0;
    tick(1);
    s_rdy_ = 1'b1;
    tick(10);
    check_val("t3_no_tmo", tmo_cnt, 0);
    check_val("t3_hold", m_grnt_, 4'b1101);
    m_req_ = 4'hF;
    tick(1);
    check_val("t3_release", m_grnt_, 4'hF);

    // 4: owner 2 strobes, ready never comes: timeout after 8 clocks, hand off to 3
    m_req_ = 4'b1011; exp_q.push_back(2);
    tick(1);
    check_val("t4_owner", owner, 2);
    m_as_[2] = 1'b0; m_req_[3] = 1'b0; exp_q.push_back(3);
    tick(1);
    m_as_[2] = 1'b1;
    tick(7);
    check_val("t4_tmo_early", timeout, 0);
    check_val("t4_grnt_early", m_grnt_, 4'b1011);
    tick(1);
    m_req_[2] = 1'b1;
    check_val("t4_tmo", timeout, 1);
    check_val("t4_tmo_mst", timeout_mst, 2);
    check_val("t4_grnt", m_grnt_, 4'b0111);
    check_val("t4_owner_new", owner, 3);
    tick(1);
    check_val("t4_pulse", timeout, 0);
    check_val("t4_tmo_mst_sticky", timeout_mst, 2);
    m_req_ = 4'hF;
    tick(1);

    // 6: ready arrives exactly on the expiry cycle: no timeout, grant kept
    m_req_ = 4'b1110; exp_q.push_back(0);
    tick(1);
    m_as_[0] = 1'b0;
    tick(1);
    m_as_[0] = 1'b1;
    tick(7);
    s_rdy_ = 1'b0;
    tick(1);
    s_rdy_ = 1'b1;
    check_val("t6_no_tmo", timeout, 0);
    check_val("t6_grnt", m_grnt_, 4'b1110);
    tick(10);
    check_val("t6_tmo_cnt", tmo_cnt, 1);
    check_val("t6_hold", m_grnt_, 4'b1110);

    // 5: async reset mid-transfer, then two requesters arbitrate from a fresh pointer
    m_as_[0] = 1'b0;
    #1 check_val("t5_s_as_before", s_as_, 0);
    #2 reset = 1'b0;
    #1 check_val("t5_grnt_rst", m_grnt_, 4'hF);
    check_val("t5_s_as_rst", s_as_, 1);
    check_val("t5_busy_rst", busy, 0);
    m_as_ = 4'hF; m_req_ = 4'hF;
    tick(1);
    reset = 1'b1;
    m_req_ = 4'b1001; exp_q.push_back(1); exp_q.push_back(2);
    tick(1);
    check_val("t5_first", m_grnt_, 4'b1101);
    check_val("t5_owner1", owner, 1);
    m_req_[1] = 1'b1;
    tick(1);
    check_val("t5_loser", m_grnt_, 4'b1011);
    check_val("t5_owner2", owner, 2);
    m_req_ = 4'hF;
    tick(2);
    check_val("t5_idle", busy, 0);

    check_val("sb_drain", exp_q.size(), 0);
    check_val("tmo_total", tmo_cnt, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
